// File: rtl/s2p_pkg.sv
// Shared types and helpers for the comma-aligned serial-to-parallel deserializer.
package s2p_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      ALIGN  = 2'd1,
      LOCKED = 2'd2
   } s2p_state_e;

   localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

   // Bits needed to hold 0..max_val, never less than one bit
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/s2p_comma_detect.sv
// Serial shift register with combinational next-window and comma match.
module s2p_comma_detect
   import s2p_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] COMMA     = WIDTH'(COMMA_DEFAULT),
   parameter bit               MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             bit_i,
   output logic [WIDTH-1:0] nxt_c_o,
   output logic             comma_hit_c_o
);

   logic [WIDTH-1:0] sr_q;

   // Window as it will look after this edge; bit order selects shift direction
   generate
      if (MSB_FIRST) begin : g_msb
         assign nxt_c_o = {sr_q[WIDTH-2:0], bit_i};
      end else begin : g_lsb
         assign nxt_c_o = {bit_i, sr_q[WIDTH-1:1]};
      end
   endgenerate

   assign comma_hit_c_o = (nxt_c_o == COMMA);

   // Shift register advances on every edge regardless of alignment state
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         sr_q <= '0;
      end else begin
         sr_q <= nxt_c_o;
      end
   end

endmodule

// File: rtl/serial_to_parallel_sync.sv
// Comma-aligned deserializer: hunt, confirm alignment, then emit strobed words.
module serial_to_parallel_sync
   import s2p_pkg::*;
#(
   parameter int unsigned      WIDTH      = 8,
   parameter logic [WIDTH-1:0] COMMA      = WIDTH'(COMMA_DEFAULT),
   parameter int unsigned      LOCK_COUNT = 4,
   parameter int unsigned      LOS_COUNT  = 4,
   parameter bit               MSB_FIRST  = 1'b0
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             word_stb,
   output logic             locked
);

   localparam int unsigned       BIT_W    = $clog2(WIDTH);
   localparam int unsigned       LOCK_W   = cnt_width(LOCK_COUNT);
   localparam int unsigned       ERR_W    = cnt_width(LOS_COUNT);
   localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(WIDTH - 1);
   localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_COUNT);
   localparam logic [ERR_W-1:0]  ERR_MAX  = ERR_W'(LOS_COUNT);

   s2p_state_e        state_q, state_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic [WIDTH-1:0]  data_out_q, data_out_d;
   logic              valid_q, valid_d;
   logic              stb_q, stb_d;
   logic              locked_q, locked_d;

   logic [WIDTH-1:0]  nxt;
   logic              comma_hit;
   logic              boundary;

   s2p_comma_detect #(
      .WIDTH     (WIDTH),
      .COMMA     (COMMA),
      .MSB_FIRST (MSB_FIRST)
   ) u_detect (
      .clk           (clk),
      .reset_L       (reset_L),
      .bit_i         (data_in),
      .nxt_c_o       (nxt),
      .comma_hit_c_o (comma_hit)
   );

   assign boundary = (bit_cnt_q == BIT_LAST);

   // Next-state, counters and output words; everything holds unless changed below
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      lock_cnt_d = lock_cnt_q;
      err_cnt_d  = err_cnt_q;
      data_out_d = data_out_q;
      valid_d    = valid_q;
      stb_d      = 1'b0;
      locked_d   = locked_q;

      unique case (state_q)
         HUNT: begin
            if (comma_hit) begin
               bit_cnt_d  = '0;
               lock_cnt_d = LOCK_W'(1);
               if (LOCK_COUNT == 1) begin
                  state_d   = LOCKED;
                  err_cnt_d = '0;
                  locked_d  = 1'b1;
               end else begin
                  state_d = ALIGN;
               end
            end
         end

         ALIGN: begin
            bit_cnt_d = boundary ? '0 : bit_cnt_q + BIT_W'(1);
            if (boundary) begin
               if (comma_hit) begin
                  if (lock_cnt_q != LOCK_MAX) begin
                     lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                  end
                  if (lock_cnt_q >= LOCK_MAX - LOCK_W'(1)) begin
                     state_d   = LOCKED;
                     err_cnt_d = '0;
                     locked_d  = 1'b1;
                  end
               end else begin
                  state_d    = HUNT;
                  lock_cnt_d = '0;
                  bit_cnt_d  = '0;
               end
            end
         end

         LOCKED: begin
            bit_cnt_d = boundary ? '0 : bit_cnt_q + BIT_W'(1);
            if (boundary) begin
               data_out_d = nxt;
               stb_d      = 1'b1;
               valid_d    = !comma_hit;
               if (comma_hit) begin
                  err_cnt_d = '0;
               end
            end else if (comma_hit && (LOS_COUNT != 0)) begin
               // Misaligned comma: drop lock once enough have been seen in a row
               if (err_cnt_q >= ERR_MAX - ERR_W'(1)) begin
                  state_d    = HUNT;
                  locked_d   = 1'b0;
                  valid_d    = 1'b0;
                  data_out_d = '0;
                  bit_cnt_d  = '0;
                  lock_cnt_d = '0;
                  err_cnt_d  = '0;
               end else begin
                  err_cnt_d = err_cnt_q + ERR_W'(1);
               end
            end
         end

         default: begin
            state_d    = HUNT;
            bit_cnt_d  = '0;
            lock_cnt_d = '0;
            err_cnt_d  = '0;
            data_out_d = '0;
            valid_d    = 1'b0;
            locked_d   = 1'b0;
         end
      endcase
   end

   // State, counter and output registers
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= HUNT;
         bit_cnt_q  <= '0;
         lock_cnt_q <= '0;
         err_cnt_q  <= '0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
         stb_q      <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         lock_cnt_q <= lock_cnt_d;
         err_cnt_q  <= err_cnt_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         stb_q      <= stb_d;
         locked_q   <= locked_d;
      end
   end

   assign data_out  = data_out_q;
   assign valid_out = valid_q;
   assign word_stb  = stb_q;
   assign locked    = locked_q;

endmodule
